// File: rtl/regbank_8_pkg.sv
// Shared constants for the eight-register bank: widths, the one-hot-low
// select codes and the scan FSM state encoding.
package regbank_8_pkg;

  localparam int DATAWIDTH_BUS_DEF = 32;
  localparam int DATAWIDTH_SEL_DEF = 8;

  localparam logic [7:0] SEL_CH0  = 8'b1111_1110;
  localparam logic [7:0] SEL_CH1  = 8'b1111_1101;
  localparam logic [7:0] SEL_CH2  = 8'b1111_1011;
  localparam logic [7:0] SEL_CH3  = 8'b1111_0111;
  localparam logic [7:0] SEL_CH4  = 8'b1110_1111;
  localparam logic [7:0] SEL_CH5  = 8'b1101_1111;
  localparam logic [7:0] SEL_CH6  = 8'b1011_1111;
  localparam logic [7:0] SEL_CH7  = 8'b0111_1111;
  localparam logic [7:0] SEL_NONE = 8'b1111_1111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

endpackage

// File: rtl/regbank_8_if.sv
// Bus bundle of the register bank.
// All strobes are level-sampled on the rising clock edge; there is no
// valid/ready back-pressure: a write or scan request is taken the edge it is seen.
interface regbank_8_if
  import regbank_8_pkg::*;
#(
   parameter int DATAWIDTH_BUS = DATAWIDTH_BUS_DEF,
   parameter int DATAWIDTH_SEL = DATAWIDTH_SEL_DEF
) ();
   logic                     REGBANK_8_clear_InLow;
   logic                     REGBANK_8_write_InLow;
   logic [DATAWIDTH_SEL-1:0] REGBANK_8_writeSel_InBUS;
   logic [DATAWIDTH_BUS-1:0] REGBANK_8_data_InBUS;
   logic                     REGBANK_8_scanStart_InLow;
   logic [DATAWIDTH_BUS-1:0] REGBANK_8_data0_OutBUS;
   logic [DATAWIDTH_BUS-1:0] REGBANK_8_data1_OutBUS;
   logic [DATAWIDTH_BUS-1:0] REGBANK_8_data2_OutBUS;
   logic [DATAWIDTH_BUS-1:0] REGBANK_8_data3_OutBUS;
   logic [DATAWIDTH_BUS-1:0] REGBANK_8_data4_OutBUS;
   logic [DATAWIDTH_BUS-1:0] REGBANK_8_data5_OutBUS;
   logic [DATAWIDTH_BUS-1:0] REGBANK_8_data6_OutBUS;
   logic [DATAWIDTH_BUS-1:0] REGBANK_8_data7_OutBUS;
   logic [DATAWIDTH_SEL-1:0] REGBANK_8_readSel_OutBUS;
   logic                     REGBANK_8_scanBusy_Out;
   logic                     REGBANK_8_writeErr_Out;
   scan_state_e              REGBANK_8_state_OutDbg;

   modport master (
      output REGBANK_8_clear_InLow, REGBANK_8_write_InLow, REGBANK_8_writeSel_InBUS,
             REGBANK_8_data_InBUS, REGBANK_8_scanStart_InLow,
      input  REGBANK_8_data0_OutBUS, REGBANK_8_data1_OutBUS, REGBANK_8_data2_OutBUS,
             REGBANK_8_data3_OutBUS, REGBANK_8_data4_OutBUS, REGBANK_8_data5_OutBUS,
             REGBANK_8_data6_OutBUS, REGBANK_8_data7_OutBUS, REGBANK_8_readSel_OutBUS,
             REGBANK_8_scanBusy_Out, REGBANK_8_writeErr_Out, REGBANK_8_state_OutDbg
   );

   modport slave (
      input  REGBANK_8_clear_InLow, REGBANK_8_write_InLow, REGBANK_8_writeSel_InBUS,
             REGBANK_8_data_InBUS, REGBANK_8_scanStart_InLow,
      output REGBANK_8_data0_OutBUS, REGBANK_8_data1_OutBUS, REGBANK_8_data2_OutBUS,
             REGBANK_8_data3_OutBUS, REGBANK_8_data4_OutBUS, REGBANK_8_data5_OutBUS,
             REGBANK_8_data6_OutBUS, REGBANK_8_data7_OutBUS, REGBANK_8_readSel_OutBUS,
             REGBANK_8_scanBusy_Out, REGBANK_8_writeErr_Out, REGBANK_8_state_OutDbg
   );
endinterface

// File: rtl/regbank_8_reg_general.sv
// One storage word: async reset, synchronous clear (dominant), load enable.
module reg_general #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);
   logic [WIDTH-1:0] word_q;
   logic [WIDTH-1:0] word_d;

   always_comb begin
      word_d = word_q;
      if (clear_i)     word_d = '0;
      else if (load_i) word_d = d_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) word_q <= '0;
      else       word_q <= word_d;
   end

   assign q_o = word_q;
endmodule

// File: rtl/regbank_8.sv
// Eight-word register bank with one-hot-low write decode, sticky write-error
// flag and a scan FSM that walks an active-low read select across all eight words.
module regbank_8
  import regbank_8_pkg::*;
#(
   parameter int DATAWIDTH_BUS = DATAWIDTH_BUS_DEF,
   parameter int DATAWIDTH_SEL = DATAWIDTH_SEL_DEF
) (
   input  logic        REGBANK_8_CLOCK_50,
   input  logic        REGBANK_8_RESET_InHigh,
   regbank_8_if.slave  bus
);
   logic                     clr;
   logic                     wr;
   logic                     sel_ok;
   logic [DATAWIDTH_BUS-1:0] word_w [8];
   logic                     werr_q, werr_d;
   scan_state_e              state_q, state_d;
   logic [DATAWIDTH_SEL-1:0] readsel_q, readsel_d;

   assign clr    = ~bus.REGBANK_8_clear_InLow;
   assign wr     = ~bus.REGBANK_8_write_InLow;
   assign sel_ok = ($countones(~bus.REGBANK_8_writeSel_InBUS) == 1);

   for (genvar n = 0; n < 8; n++) begin : g_word
      reg_general #(.WIDTH(DATAWIDTH_BUS)) u_reg (
         .clk_i   (REGBANK_8_CLOCK_50),
         .rst_i   (REGBANK_8_RESET_InHigh),
         .clear_i (clr),
         .load_i  (wr && sel_ok && !bus.REGBANK_8_writeSel_InBUS[n]),
         .d_i     (bus.REGBANK_8_data_InBUS),
         .q_o     (word_w[n])
      );
   end

   always_comb begin
      werr_d = werr_q;
      if (clr)              werr_d = 1'b0;
      else if (wr && !sel_ok) werr_d = 1'b1;
   end

   // readSel is a plain rotate: it starts at channel 0 and wraps back to
   // channel 0 on the final scan edge, so it is never all-ones or multi-low.
   always_comb begin
      state_d   = state_q;
      readsel_d = readsel_q;
      case (state_q)
         ST_IDLE: begin
            if (!bus.REGBANK_8_scanStart_InLow) begin
               state_d   = ST_SCAN;
               readsel_d = SEL_CH0[DATAWIDTH_SEL-1:0];
            end
         end
         ST_SCAN: begin
            readsel_d = {readsel_q[DATAWIDTH_SEL-2:0], readsel_q[DATAWIDTH_SEL-1]};
            if (!readsel_q[DATAWIDTH_SEL-1]) state_d = ST_IDLE;
         end
         default: begin
            state_d   = ST_IDLE;
            readsel_d = SEL_CH0[DATAWIDTH_SEL-1:0];
         end
      endcase
   end

   always_ff @(posedge REGBANK_8_CLOCK_50 or posedge REGBANK_8_RESET_InHigh) begin
      if (REGBANK_8_RESET_InHigh) begin
         state_q   <= ST_IDLE;
         readsel_q <= SEL_CH0[DATAWIDTH_SEL-1:0];
         werr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         readsel_q <= readsel_d;
         werr_q    <= werr_d;
      end
   end

   assign bus.REGBANK_8_data0_OutBUS   = word_w[0];
   assign bus.REGBANK_8_data1_OutBUS   = word_w[1];
   assign bus.REGBANK_8_data2_OutBUS   = word_w[2];
   assign bus.REGBANK_8_data3_OutBUS   = word_w[3];
   assign bus.REGBANK_8_data4_OutBUS   = word_w[4];
   assign bus.REGBANK_8_data5_OutBUS   = word_w[5];
   assign bus.REGBANK_8_data6_OutBUS   = word_w[6];
   assign bus.REGBANK_8_data7_OutBUS   = word_w[7];
   assign bus.REGBANK_8_readSel_OutBUS = readsel_q;
   assign bus.REGBANK_8_scanBusy_Out   = (state_q == ST_SCAN);
   assign bus.REGBANK_8_writeErr_Out   = werr_q;
   assign bus.REGBANK_8_state_OutDbg   = state_q;
endmodule

// File: tb/tb_regbank_8.sv
// Randomized and directed bench for regbank_8 against a behavioural model.
module tb_regbank_8;
  import regbank_8_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [31:0] model_regs [8];
  logic        model_err;
  int          model_pos;  // -1 idle, 0..7 scan slot being driven
  logic [31:0] exp_q [$];

  regbank_8_if #(.DATAWIDTH_BUS(32), .DATAWIDTH_SEL(8)) bus ();

  regbank_8 #(.DATAWIDTH_BUS(32), .DATAWIDTH_SEL(8)) dut (
    .REGBANK_8_CLOCK_50     (clk),
    .REGBANK_8_RESET_InHigh (rst),
    .bus                    (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dut_word(input int i);
    case (i)
      0: return bus.REGBANK_8_data0_OutBUS;
      1: return bus.REGBANK_8_data1_OutBUS;
      2: return bus.REGBANK_8_data2_OutBUS;
      3: return bus.REGBANK_8_data3_OutBUS;
      4: return bus.REGBANK_8_data4_OutBUS;
      5: return bus.REGBANK_8_data5_OutBUS;
      6: return bus.REGBANK_8_data6_OutBUS;
      default: return bus.REGBANK_8_data7_OutBUS;
    endcase
  endfunction

  function automatic logic [7:0] model_sel();
    logic [7:0] one;
    one = 8'h01;
    if (model_pos < 0) return 8'hFE;
    return ~(one << model_pos);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) model_regs[i] = '0;
    model_err = 1'b0;
    model_pos = -1;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s data%0d", tag, i), dut_word(i), model_regs[i]);
    check({tag, " readSel"}, 32'(bus.REGBANK_8_readSel_OutBUS), 32'(model_sel()));
    check({tag, " scanBusy"}, 32'(bus.REGBANK_8_scanBusy_Out), 32'(model_pos >= 0));
    check({tag, " writeErr"}, 32'(bus.REGBANK_8_writeErr_Out), 32'(model_err));
    check({tag, " state"}, 32'(bus.REGBANK_8_state_OutDbg == ST_SCAN), 32'(model_pos >= 0));
  endtask

  // driver: one clock with current inputs, model advanced from the same inputs
  task automatic tick(input string tag);
    int zeros;
    int idx;
    zeros = 0;
    idx = 0;
    for (int i = 0; i < 8; i++)
      if (!bus.REGBANK_8_writeSel_InBUS[i]) begin zeros++; idx = i; end
    if (!bus.REGBANK_8_clear_InLow) begin
      for (int i = 0; i < 8; i++) model_regs[i] = '0;
      model_err = 1'b0;
    end else if (!bus.REGBANK_8_write_InLow) begin
      if (zeros == 1) model_regs[idx] = bus.REGBANK_8_data_InBUS;
      else            model_err = 1'b1;
    end
    if (model_pos < 0) begin
      if (!bus.REGBANK_8_scanStart_InLow) model_pos = 0;
    end else begin
      model_pos = (model_pos == 7) ? -1 : model_pos + 1;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    bus.REGBANK_8_clear_InLow     = 1'b1;
    bus.REGBANK_8_write_InLow     = 1'b1;
    bus.REGBANK_8_writeSel_InBUS  = SEL_NONE;
    bus.REGBANK_8_data_InBUS      = '0;
    bus.REGBANK_8_scanStart_InLow = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write(input logic [7:0] sel, input logic [31:0] d, input string tag);
    bus.REGBANK_8_write_InLow    = 1'b0;
    bus.REGBANK_8_writeSel_InBUS = sel;
    bus.REGBANK_8_data_InBUS     = d;
    tick(tag);
    idle_inputs();
  endtask

  initial begin
    int busy_cnt;
    int idle_cnt;
    logic [7:0] one;
    logic [7:0] sel;
    total = 0;
    bad = 0;
    idle_inputs();
    do_reset();

    // single legal write to register 2
    write(8'b1111_1011, 32'hDEADBEEF, "wr2");
    check("wr2 direct", bus.REGBANK_8_data2_OutBUS, 32'hDEADBEEF);

    // illegal select: sticky error until clear
    write(8'b1111_1100, 32'h1, "badsel");
    check("badsel err", 32'(bus.REGBANK_8_writeErr_Out), 32'h1);
    tick("err hold1");
    tick("err hold2");
    write(SEL_NONE, 32'h7, "allones");
    bus.REGBANK_8_clear_InLow = 1'b0;
    tick("clear");
    idle_inputs();
    check("clear err", 32'(bus.REGBANK_8_writeErr_Out), 32'h0);

    // clear beats simultaneous write
    bus.REGBANK_8_clear_InLow = 1'b0;
    bus.REGBANK_8_write_InLow = 1'b0;
    bus.REGBANK_8_writeSel_InBUS = SEL_CH0;
    bus.REGBANK_8_data_InBUS = 32'h55;
    tick("clr_vs_wr");
    idle_inputs();
    check("clr_vs_wr data0", bus.REGBANK_8_data0_OutBUS, 32'h0);

    // load regN = N+1 then one scan
    one = 8'h01;
    for (int n = 0; n < 8; n++) write(~(one << n), 32'(n + 1), "load");
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(~(one << i)) & 32'hFF);
    busy_cnt = 0;
    bus.REGBANK_8_scanStart_InLow = 1'b0;
    for (int c = 0; c < 9; c++) begin
      tick("scan");
      bus.REGBANK_8_scanStart_InLow = 1'b1;
      if (bus.REGBANK_8_scanBusy_Out) busy_cnt++;
      if (exp_q.size() > 0) check("scan seq", 32'(bus.REGBANK_8_readSel_OutBUS), exp_q.pop_front());
    end
    check("scan busy cycles", 32'(busy_cnt), 32'd8);
    check("scan end sel", 32'(bus.REGBANK_8_readSel_OutBUS), 32'hFE);

    // reset mid-scan at readSel = 11101111
    bus.REGBANK_8_scanStart_InLow = 1'b0;
    tick("pre-abort");
    bus.REGBANK_8_scanStart_InLow = 1'b1;
    for (int c = 0; c < 4; c++) tick("pre-abort");
    check("abort point", 32'(bus.REGBANK_8_readSel_OutBUS), 32'(SEL_CH4));
    #2;
    do_reset();
    tick("post-abort idle");

    // scanStart held low for 20 cycles
    busy_cnt = 0;
    idle_cnt = 0;
    bus.REGBANK_8_scanStart_InLow = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick("hold");
      if (bus.REGBANK_8_scanBusy_Out) busy_cnt++;
      else idle_cnt++;
    end
    idle_inputs();
    check("hold busy cycles", 32'(busy_cnt), 32'd18);
    check("hold idle cycles", 32'(idle_cnt), 32'd2);
    check("hold third scan", 32'(bus.REGBANK_8_readSel_OutBUS), 32'(SEL_CH1));

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      case ($urandom_range(0, 3))
        0:       sel = SEL_NONE;
        1:       sel = 8'($urandom);
        default: sel = ~(one << $urandom_range(0, 7));
      endcase
      bus.REGBANK_8_writeSel_InBUS  = sel;
      bus.REGBANK_8_data_InBUS      = $urandom;
      bus.REGBANK_8_write_InLow     = ($urandom_range(0, 2) == 0);
      bus.REGBANK_8_clear_InLow     = ($urandom_range(0, 15) != 0);
      bus.REGBANK_8_scanStart_InLow = ($urandom_range(0, 3) != 0);
      tick("rand");
    end
    idle_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout: got no finish expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regbank_8.md
REGBANK_8 -- requirements
Module: regbank_8

Interface
REQ-001 Parameter DATAWIDTH_BUS, default 32, width of every data word.
REQ-002 Parameter DATAWIDTH_SEL, default 8, width of the active-low one-hot select buses.
REQ-003 REGBANK_8_CLOCK_50  in  1  sole clock; all state updates on its rising edge.
REQ-004 REGBANK_8_RESET_InHigh  in  1  asynchronous, active-high reset.
REQ-005 REGBANK_8_clear_InLow  in  1  synchronous clear of all registers and the error flag, active-low.
REQ-006 REGBANK_8_write_InLow  in  1  write strobe, active-low.
REQ-007 REGBANK_8_writeSel_InBUS  in  DATAWIDTH_SEL  write target, active-low one-hot (bit n low = register n).
REQ-008 REGBANK_8_data_InBUS  in  DATAWIDTH_BUS  write data.
REQ-009 REGBANK_8_scanStart_InLow  in  1  scan request, active-low, level-sampled.
REQ-010 REGBANK_8_data0_OutBUS..REGBANK_8_data7_OutBUS  out  DATAWIDTH_BUS each  register contents, feed the 8-way data mux inputs 0..7.
REQ-011 REGBANK_8_readSel_OutBUS  out  DATAWIDTH_SEL  active-low one-hot read select driving the downstream 8-way mux select.
REQ-012 REGBANK_8_scanBusy_Out  out  1  high while a scan is in progress.
REQ-013 REGBANK_8_writeErr_Out  out  1  sticky flag: a write carried an illegal select.

Function
REQ-014 The block SHALL hold eight DATAWIDTH_BUS registers; each dataN output is the registered value, no combinational path from data_InBUS.
REQ-015 A write SHALL occur on the edge where write_InLow=0 and writeSel has exactly one bit low; the target updates at that edge, visible on its output the following cycle.
REQ-016 Write with writeSel not exactly-one-low (all ones, or two or more zeros) SHALL change no register and SHALL set writeErr at that edge.
REQ-017 writeErr SHALL stay high until clear_InLow=0 or reset.
REQ-018 clear_InLow=0 SHALL zero all eight registers and writeErr at the edge; clear SHALL win over a simultaneous write.
REQ-019 Scan FSM states: IDLE, SCAN. IDLE: readSel holds its value, scanBusy=0.
REQ-020 IDLE with scanStart_InLow=0 SHALL move to SCAN, set readSel=8'b11111110 and scanBusy=1 at that edge.
REQ-021 In SCAN each edge SHALL rotate readSel left by one, filling with 1 (11111110 -> 11111101 -> ... -> 01111111).
REQ-022 In SCAN with readSel=01111111 the next edge SHALL return to IDLE with readSel=11111110, scanBusy=0; scanBusy is high exactly 8 cycles per scan.
REQ-023 scanStart during SCAN SHALL be ignored; held low at scan end, a new scan SHALL start on the next IDLE edge (one idle cycle between scans).
REQ-024 Writes and clear SHALL operate normally during SCAN without disturbing the scan sequence.
REQ-025 readSel SHALL always be exactly-one-low; all-ones or multi-low values SHALL never be driven.

Reset
REQ-026 Reset high SHALL asynchronously force: all registers 0, readSel=8'b11111110, scanBusy=0, writeErr=0, FSM=IDLE.
REQ-027 Reset mid-scan SHALL abort the scan; after release the block is in IDLE and needs a new scanStart.
REQ-028 Reset SHALL override clear, write and scanStart.

Structure
REQ-029 A shared package SHALL hold DATAWIDTH_BUS/DATAWIDTH_SEL defaults, the eight select constants SEL_CH0..SEL_CH7 (11111110..01111111), SEL_NONE (11111111), and the FSM state encoding.
REQ-030 Each storage word SHALL be an instance of a sub-module reg_general (register with async reset, sync clear, load enable); eight instances.

Verification
REQ-031 Reset, then write_InLow=0, writeSel=11111011, data=32'hDEADBEEF -> data2_OutBUS=32'hDEADBEEF next cycle, others 0, writeErr=0.
REQ-032 Write with writeSel=11111100, data=32'h1 -> no register changes, writeErr=1 and stays 1 until clear_InLow=0, then 0.
REQ-033 Load regN=N+1, pulse scanStart one cycle -> readSel steps 11111110..01111111 over 8 cycles, scanBusy high 8 cycles, then readSel=11111110, scanBusy=0.
REQ-034 Same cycle write_InLow=0 (writeSel=11111110, data=32'h55) and clear_InLow=0 -> data0_OutBUS=0.
REQ-035 Assert reset while readSel=11101111 mid-scan -> immediately readSel=11111110, scanBusy=0, all data outputs 0.
REQ-036 Hold scanStart_InLow=0 for 20 cycles -> two scans of 8 busy cycles separated by one idle cycle, then a third starting.
